// File: rtl/decode_if.sv
// Decode-to-execute bundle: the D-stage results handed to execute.
// decode drives it through the master modport; execute listens as slave.
interface decode_if;
    logic [2:0]  d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;

    modport master (
        output d_stat, d_icode, d_ifun, d_valC,
        output d_valA, d_valB,
        output d_srcA, d_srcB, d_dstE, d_dstM
    );

    modport slave (
        input d_stat, d_icode, d_ifun, d_valC,
        input d_valA, d_valB,
        input d_srcA, d_srcB, d_dstE, d_dstM
    );
endinterface

// File: rtl/decode.sv
// Y86-64 decode stage: D pipeline register, 15x64 register file,
// register-ID decode and forwarded operands valA/valB.
// Ports: clk, rst_n (sync, active-low); f_* fetch outputs;
// D_stall/D_bubble; e/M/W forward sources (W also writes the regfile);
// D_icode for hazard control; dout carries the d_* bundle to execute.
module decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  f_stat,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    output logic [3:0]  D_icode,
    decode_if.master    dout
);
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [3:0] RSP      = 4'd4;
    localparam logic [3:0] RNONE    = 4'd15;

    logic [2:0]  D_stat;
    logic [3:0]  D_ifun;
    logic [3:0]  D_rA;
    logic [3:0]  D_rB;
    logic [63:0] D_valC;
    logic [63:0] D_valP;

    logic [63:0] rf [0:14];

    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic [63:0] val_a;
    logic [63:0] val_b;

    // D register: reset and bubble load the same NOP contents;
    // stall takes priority over bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || (!D_stall && D_bubble)) begin
            D_stat  <= S_AOK;
            D_icode <= I_NOP;
            D_ifun  <= 4'd0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= 64'd0;
            D_valP  <= 64'd0;
        end else if (!D_stall) begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
        end
    end

    // Writeback port. The M write is issued last so it wins when
    // both target the same register (popq %rsp).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                rf[i] <= 64'd0;
            end
        end else begin
            if (W_dstE != RNONE) begin
                rf[W_dstE] <= W_valE;
            end
            if (W_dstM != RNONE) begin
                rf[W_dstM] <= W_valM;
            end
        end
    end

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            I_RRMOVQ: begin
                src_a = D_rA;
                dst_e = D_rB;
            end
            I_IRMOVQ: begin
                dst_e = D_rB;
            end
            I_RMMOVQ: begin
                src_a = D_rA;
                src_b = D_rB;
            end
            I_MRMOVQ: begin
                src_b = D_rB;
                dst_m = D_rA;
            end
            I_OPQ: begin
                src_a = D_rA;
                src_b = D_rB;
                dst_e = D_rB;
            end
            I_CALL: begin
                src_b = RSP;
                dst_e = RSP;
            end
            I_RET: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
            end
            I_PUSHQ: begin
                src_a = D_rA;
                src_b = RSP;
                dst_e = RSP;
            end
            I_POPQ: begin
                src_a = RSP;
                src_b = RSP;
                dst_e = RSP;
                dst_m = D_rA;
            end
            default: ;
        endcase
    end

    // Youngest producer first; a same-cycle W write reaches the
    // reader here because the array only updates at the edge.
    function automatic logic [63:0] fwd(input logic [3:0] src);
        if (src == RNONE)
            return 64'd0;
        else if (src == e_dstE)
            return e_valE;
        else if (src == M_dstM)
            return m_valM;
        else if (src == M_dstE)
            return M_valE;
        else if (src == W_dstM)
            return W_valM;
        else if (src == W_dstE)
            return W_valE;
        else
            return rf[src];
    endfunction

    always_comb begin
        val_a = fwd(src_a);
        val_b = fwd(src_b);
        // call/jxx carry the fall-through PC down the valA lane
        if (D_icode == I_CALL || D_icode == I_JXX) begin
            val_a = D_valP;
        end
    end

    assign dout.d_stat  = D_stat;
    assign dout.d_icode = D_icode;
    assign dout.d_ifun  = D_ifun;
    assign dout.d_valC  = D_valC;
    assign dout.d_valA  = val_a;
    assign dout.d_valB  = val_b;
    assign dout.d_srcA  = src_a;
    assign dout.d_srcB  = src_b;
    assign dout.d_dstE  = dst_e;
    assign dout.d_dstM  = dst_m;
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: expected bundles are queued as each step
// is driven and popped for comparison once the outputs settle.
module tb_decode;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  f_stat;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        D_stall, D_bubble;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  D_icode;

    decode_if dif ();

    decode dut (
        .clk(clk), .rst_n(rst_n),
        .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .D_stall(D_stall), .D_bubble(D_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE),
        .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .W_dstM(W_dstM), .W_valM(W_valM),
        .D_icode(D_icode),
        .dout(dif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valC;
        logic [3:0]  srcA, srcB, dstE, dstM;
        logic [63:0] valA, valB;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc,
                         input logic [63:0] vp);
        f_stat  = 3'd1;
        f_icode = ic;
        f_ifun  = 4'd0;
        f_rA    = ra;
        f_rB    = rb;
        f_valC  = vc;
        f_valP  = vp;
    endtask

    task automatic clear_fwd();
        e_dstE = 4'd15; M_dstE = 4'd15; M_dstM = 4'd15;
        W_dstE = 4'd15; W_dstM = 4'd15;
        e_valE = '0; M_valE = '0; m_valM = '0;
        W_valE = '0; W_valM = '0;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ic,
                              input logic [63:0] vc,
                              input logic [3:0] sa, input logic [3:0] sb,
                              input logic [3:0] de, input logic [3:0] dm,
                              input logic [63:0] va,
                              input logic [63:0] vb);
        exp_t e;
        e.tag = tag; e.icode = ic; e.stat = 3'd1; e.valC = vc;
        e.srcA = sa; e.srcB = sb; e.dstE = de; e.dstM = dm;
        e.valA = va; e.valB = vb;
        q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h",
                   tag, fld, obs, exp);
        end
    endtask

    task automatic check();
        exp_t e;
        #1;
        checks++;
        assert (q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp(e.tag, "D_icode", 64'(D_icode), 64'(e.icode));
            cmp(e.tag, "icode", 64'(dif.d_icode), 64'(e.icode));
            cmp(e.tag, "stat", 64'(dif.d_stat), 64'(e.stat));
            cmp(e.tag, "ifun", 64'(dif.d_ifun), 64'd0);
            cmp(e.tag, "valC", dif.d_valC, e.valC);
            cmp(e.tag, "srcA", 64'(dif.d_srcA), 64'(e.srcA));
            cmp(e.tag, "srcB", 64'(dif.d_srcB), 64'(e.srcB));
            cmp(e.tag, "dstE", 64'(dif.d_dstE), 64'(e.dstE));
            cmp(e.tag, "dstM", 64'(dif.d_dstM), 64'(e.dstM));
            cmp(e.tag, "valA", dif.d_valA, e.valA);
            cmp(e.tag, "valB", dif.d_valB, e.valB);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        D_stall = 1'b0;
        D_bubble = 1'b0;
        clear_fwd();
        fetch(4'd6, 4'd2, 4'd3, 64'd0, 64'd0);

        // reset holds D at bubble even with an opq at fetch
        expect_out("reset", 4'd1, 0, 15, 15, 15, 15, 0, 0);
        tick(); tick();
        check();

        rst_n = 1'b1;
        expect_out("opq23", 4'd6, 0, 2, 3, 3, 15, 0, 0);
        tick();
        check();

        // W writes rf[5] at this edge; no forward afterwards
        W_dstE = 4'd5; W_valE = 64'hDEAD;
        fetch(4'd6, 4'd5, 4'd6, 64'd0, 64'd0);
        expect_out("wb_read", 4'd6, 0, 5, 6, 6, 15, 64'hDEAD, 0);
        tick();
        clear_fwd();
        check();

        // both W ports to %rsp: valM wins; popq decode
        W_dstE = 4'd4; W_valE = 64'd1;
        W_dstM = 4'd4; W_valM = 64'd2;
        fetch(4'd11, 4'd7, 4'd15, 64'd0, 64'd0);
        expect_out("popq", 4'd11, 0, 4, 4, 4, 7, 64'd2, 64'd2);
        tick();
        clear_fwd();
        check();

        fetch(4'd6, 4'd3, 4'd5, 64'd0, 64'd0);
        expect_out("fwd_e", 4'd6, 0, 3, 5, 5, 15, 64'h11, 64'hDEAD);
        tick();
        e_dstE = 4'd3; e_valE = 64'h11;
        M_dstM = 4'd3; m_valM = 64'h22;
        W_dstE = 4'd3; W_valE = 64'h33;
        check();

        e_dstE = 4'd15;
        expect_out("fwd_m", 4'd6, 0, 3, 5, 5, 15, 64'h22, 64'hDEAD);
        check();

        M_dstM = 4'd15;
        M_dstE = 4'd5; M_valE = 64'h55;
        expect_out("fwd_w", 4'd6, 0, 3, 5, 5, 15, 64'h33, 64'h55);
        check();

        clear_fwd();
        fetch(4'd8, 4'd15, 4'd15, 64'h100, 64'h40);
        expect_out("call", 4'd8, 64'h100, 15, 4, 4, 15,
                   64'h40, 64'h99);
        tick();
        e_dstE = 4'd4; e_valE = 64'h99;
        check();
        clear_fwd();

        fetch(4'd10, 4'd5, 4'd15, 64'd0, 64'd0);
        expect_out("pushq", 4'd10, 0, 5, 4, 4, 15, 64'hDEAD, 64'd2);
        tick();
        check();

        D_stall = 1'b1;
        fetch(4'd3, 4'd15, 4'd9, 64'h77, 64'h88);
        for (int i = 0; i < 2; i++) begin
            expect_out("stall", 4'd10, 0, 5, 4, 4, 15,
                       64'hDEAD, 64'd2);
            tick();
            check();
        end

        D_bubble = 1'b1;
        expect_out("stall_bub", 4'd10, 0, 5, 4, 4, 15,
                   64'hDEAD, 64'd2);
        tick();
        check();

        D_stall = 1'b0;
        expect_out("bubble", 4'd1, 0, 15, 15, 15, 15, 0, 0);
        tick();
        check();

        D_bubble = 1'b0;
        fetch(4'd3, 4'd15, 4'd15, 64'h77, 64'h88);
        expect_out("irmov_nodst", 4'd3, 64'h77, 15, 15, 15, 15, 0, 0);
        tick();
        check();

        fetch(4'd7, 4'd15, 4'd15, 64'h200, 64'h80);
        expect_out("jxx", 4'd7, 64'h200, 15, 15, 15, 15, 64'h80, 0);
        tick();
        check();

        // reset mid-stream beats a pending W write and clears rf
        rst_n = 1'b0;
        W_dstE = 4'd5; W_valE = 64'hBEEF;
        fetch(4'd6, 4'd5, 4'd4, 64'd0, 64'd0);
        expect_out("mid_reset", 4'd1, 0, 15, 15, 15, 15, 0, 0);
        tick();
        rst_n = 1'b1;
        clear_fwd();
        check();

        expect_out("rf_cleared", 4'd6, 0, 5, 4, 4, 15, 0, 0);
        tick();
        check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
